// File: rtl/fp_pkg.sv
// Shared FP32 types and constants for the sequential multiplier and the divider.
// The multiplier FSM state encoding lives here so benches and checkers can decode it.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Bit order matches the external {invalid, overflow, underflow, inexact} flag bus.
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    localparam int          FP_BIAS = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MUL    = 3'd2,
        S_NORM   = 3'd3,
        S_DONE   = 3'd4
    } mul_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise/round/pack stage: 48-bit significand product plus biased
// exponent and sign in, packed FP32 and exception flags out (flush-to-zero on underflow).
module fp_round_pack
    import fp_pkg::*;
(
    input  logic [47:0]        i_prod,
    input  logic signed [9:0]  i_exp,
    input  logic               i_sign,
    output logic [31:0]        o_result,
    output fp_flags_t          o_flags
);

    logic [47:0]       w_norm;
    logic signed [9:0] w_exp_n;
    logic [23:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp_r;
    logic [23:0]       w_mant_r;

    // A product of two [1,2) significands lies in [1,4): at most one right shift.
    assign w_norm     = i_prod[47] ? i_prod : (i_prod << 1);
    assign w_exp_n    = i_exp + (i_prod[47] ? 10'sd1 : 10'sd0);
    assign w_mant     = w_norm[47:24];
    assign w_guard    = w_norm[23];
    assign w_sticky   = |w_norm[22:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_sum      = {1'b0, w_mant} + {24'd0, w_round_up};
    assign w_exp_r    = w_exp_n + (w_sum[24] ? 10'sd1 : 10'sd0);
    assign w_mant_r   = w_sum[24] ? w_sum[24:1] : w_sum[23:0];

    always_comb begin
        o_result          = {i_sign, w_exp_r[7:0], w_mant_r[22:0]};
        o_flags           = '0;
        o_flags.inexact   = w_guard | w_sticky;
        if (w_exp_r >= 10'sd255) begin
            o_result          = i_sign ? FP_NINF : FP_PINF;
            o_flags.overflow  = 1'b1;
            o_flags.inexact   = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
            o_result          = {i_sign, 31'd0};
            o_flags.underflow = 1'b1;
            o_flags.inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_seq_multiplier.sv
// Multi-cycle FP32 multiplier: shift-add significand product, BITS_PER_CYCLE multiplier
// bits per MUL cycle, one operation in flight, valid/ready on both sides.
module fp_seq_multiplier
    import fp_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [3:0]  out_flags,
    output mul_state_t  o_dbg_state
);

    localparam int N  = 24 / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and the result is held
    // unchanged until the consumer takes it.

    mul_state_t        r_state;
    fp32_t             r_a;
    fp32_t             r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [47:0]       r_acc;
    logic [47:0]       r_mcand;
    logic [23:0]       r_mplier;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_out;
    fp_flags_t         r_flags;
    logic              r_out_valid;

    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic              w_special;
    logic              w_sign;
    logic signed [9:0] w_exp_sum;
    logic [31:0]       w_spec_res;
    fp_flags_t         w_spec_flags;
    logic [47:0]       w_pp_sum;
    logic [31:0]       w_rp_result;
    fp_flags_t         w_rp_flags;

    assign w_a_zero  = (r_a.exp == 8'd0);
    assign w_b_zero  = (r_b.exp == 8'd0);
    assign w_a_inf   = (r_a.exp == 8'hFF) && (r_a.frac == 23'd0);
    assign w_b_inf   = (r_b.exp == 8'hFF) && (r_b.frac == 23'd0);
    assign w_a_nan   = (r_a.exp == 8'hFF) && (r_a.frac != 23'd0);
    assign w_b_nan   = (r_b.exp == 8'hFF) && (r_b.frac != 23'd0);
    assign w_special = w_a_zero | w_b_zero | (r_a.exp == 8'hFF) | (r_b.exp == 8'hFF);
    assign w_sign    = r_a.sign ^ r_b.sign;
    assign w_exp_sum = $signed({2'b00, r_a.exp}) + $signed({2'b00, r_b.exp})
                     - $signed(10'(FP_BIAS));

    always_comb begin
        w_spec_res   = {w_sign, 31'd0};
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_res           = FP_QNAN;
            w_spec_flags.invalid = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_res = w_sign ? FP_NINF : FP_PINF;
        end
    end

    // The multiplicand register is pre-shifted each cycle, so partial product k of this
    // cycle is simply the multiplicand shifted by k.
    always_comb begin
        w_pp_sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_mplier[k]) begin
                w_pp_sum = w_pp_sum + (r_mcand << k);
            end
        end
    end

    fp_round_pack u_round_pack (
        .i_prod   (r_acc),
        .i_exp    (r_exp),
        .i_sign   (r_sign),
        .o_result (w_rp_result),
        .o_flags  (w_rp_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (w_special) begin
                        r_out       <= w_spec_res;
                        r_flags     <= w_spec_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_sign   <= w_sign;
                        r_exp    <= w_exp_sum;
                        r_acc    <= '0;
                        r_mcand  <= {24'd0, 1'b1, r_a.frac};
                        r_mplier <= {1'b1, r_b.frac};
                        r_cnt    <= CW'(N);
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + w_pp_sum;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_out       <= w_rp_result;
                    r_flags     <= w_rp_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign out         = r_out;
    assign out_flags   = r_flags;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Directed bench for fp_seq_multiplier: one instance with 1 bit per cycle and one with 4,
// selected through sel4; each scenario task runs against the selected instance.
module tb_fp_seq_multiplier;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sel4;
    logic [31:0] a;
    logic [31:0] b;

    logic        iv1, iv4;
    logic        ir1, ir4, ov1, ov4;
    logic [31:0] out1, out4;
    logic [3:0]  fl1, fl4;
    mul_state_t  st1, st4;

    logic        d_in_ready, d_out_valid;
    logic [31:0] d_out;
    logic [3:0]  d_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iv1         = in_valid & ~sel4;
    assign iv4         = in_valid & sel4;
    assign d_in_ready  = sel4 ? ir4  : ir1;
    assign d_out_valid = sel4 ? ov4  : ov1;
    assign d_out       = sel4 ? out4 : out1;
    assign d_flags     = sel4 ? fl4  : fl1;

    fp_seq_multiplier #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .out(out1), .out_flags(fl1),
        .o_dbg_state(st1)
    );

    fp_seq_multiplier #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
        .out_valid(ov4), .out_ready(out_ready), .out(out4), .out_flags(fl4),
        .o_dbg_state(st4)
    );

    function automatic int norm_lat();
        return sel4 ? 8 : 26;
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!d_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] exp_o, input logic [3:0] exp_f,
                          input int exp_lat, input string name);
        int lat;
        checks++;
        if (d_in_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle_in_ready: got %b want 1", name, d_in_ready);
        end
        a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (d_in_ready !== 1'b0) begin
            errors++; $display("FAIL %s busy_in_ready: got %b want 0", name, d_in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (d_out !== exp_o) begin
            errors++; $display("FAIL %s result: got %h want %h", name, d_out, exp_o);
        end
        checks++;
        if (d_flags !== exp_f) begin
            errors++; $display("FAIL %s flags: got %b want %b", name, d_flags, exp_f);
        end
        @(posedge clk); #1;
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s one_cycle_hold: got valid=%b ready=%b want valid=0 ready=1",
                     name, d_out_valid, d_in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov1 !== 1'b0 || out1 !== 32'h0 || fl1 !== 4'h0 || ir1 !== 1'b1 || st1 !== S_IDLE) begin
            errors++;
            $display("FAIL reset_x1: got valid=%b out=%h flags=%b ready=%b want 0/00000000/0000/1",
                     ov1, out1, fl1, ir1);
        end
        checks++;
        if (ov4 !== 1'b0 || out4 !== 32'h0 || fl4 !== 4'h0 || ir4 !== 1'b1 || st4 !== S_IDLE) begin
            errors++;
            $display("FAIL reset_x4: got valid=%b out=%h flags=%b ready=%b want 0/00000000/0000/1",
                     ov4, out4, fl4, ir4);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, norm_lat(), "mul_1p5x2");
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1, "inf_x_zero");
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1, "nan_in");
        run_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, 1, "inf_x_neg");
        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 1, "negzero_x2");
        run_op(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'b0101, norm_lat(), "overflow");
        run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011, norm_lat(), "underflow");
        run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, norm_lat(), "round_down");
        run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, norm_lat(), "tie_to_even");
        run_op(32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 4'b0000, norm_lat(), "neg_x_one");
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        a = 32'h4040_0000; b = 32'h4000_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== norm_lat()) begin
            errors++; $display("FAIL bp_latency: got %0d want %0d", lat, norm_lat());
        end
        for (int i = 0; i < 5; i++) begin
            a = 32'h4000_0000; b = 32'h4000_0000; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (d_out !== 32'h40C0_0000 || d_flags !== 4'b0000 || d_out_valid !== 1'b1
                || d_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got out=%h flags=%b valid=%b ready=%b want 40c00000/0000/1/0",
                         i, d_out, d_flags, d_out_valid, d_in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", d_out_valid, d_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (d_in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: got ready=%b want 0", d_in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat !== norm_lat() || d_out !== 32'h4080_0000 || d_flags !== 4'b0000) begin
            errors++;
            $display("FAIL bp_next_op: got lat=%0d out=%h flags=%b want %0d/40800000/0000",
                     lat, d_out, d_flags, norm_lat());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        a = 32'h4000_0000; b = 32'h4000_0000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (sel4 ? 3 : 10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_out_valid !== 1'b0 || d_out !== 32'h0 || d_flags !== 4'h0 || d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear: got valid=%b out=%h flags=%b ready=%b want 0/00000000/0000/1",
                     d_out_valid, d_out, d_flags, d_in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (d_out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midreset_stale: got %0d valid cycles want 0", seen);
        end
        run_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'b0000, norm_lat(), "after_reset");
    endtask

    initial begin
        test_reset();
        for (int s = 0; s < 2; s++) begin
            sel4 = (s == 1);
            @(posedge clk); #1;
            test_vectors();
            test_backpressure();
            test_reset_mid();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_seq_multiplier.md
# fp_seq_multiplier

Multi-cycle IEEE-754 single-precision multiplier built on a shift-add datapath with valid/ready handshakes on both sides. It is the forward-direction companion to the Newton-Raphson divider: it supplies the same a·b product function as a registered, area-lean unit. The divider's iteration steps and the FPU issue logic can time-share it. One operation is in flight at a time.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits consumed per MUL cycle. Legal values are 1, 2, 4, 8. Define N = 24 / BITS_PER_CYCLE.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operands present
- `in_ready`  out  1  unit idle, equal to (state == IDLE)
- `a`  in  32  operand A, FP32
- `b`  in  32  operand B, FP32
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer accepts result
- `out`  out  32  FP32 product
- `out_flags`  out  4  {invalid, overflow, underflow, inexact}

## Operation
- FSM states: IDLE → UNPACK → MUL → NORM → DONE → IDLE. Special cases take UNPACK → DONE.
- **IDLE.** On in_valid && in_ready, register a and b, then go to UNPACK.
- **UNPACK.** Exponent 0 is treated as zero; denormals are flushed on input.
  - sign = sa ^ sb.
  - Exponent: 10-bit signed e = ea + eb − 127.
  - Significands take the implicit 1: {1, frac}.
  - Specials, result written directly:
    - any NaN, or inf·0 → 0x7FC00000, invalid = 1.
    - inf·finite-nonzero → signed inf (sign ? 0xFF800000 : 0x7F800000).
    - zero·finite → signed zero.
- **MUL.** Runs N cycles.
  - Each cycle adds BITS_PER_CYCLE partial products of A's significand, selected by the low bits of B's shift register, into a 48-bit accumulator.
  - The multiplier register then shifts right by BITS_PER_CYCLE.
  - A down-counter of width ⌈log2(N+1)⌉ terminates the state.
- **NORM**, done in the fp_round_pack sub-module:
  - If P[47] is set, shift right 1 and e += 1.
  - Keep 24 bits, guard = next bit, sticky = OR of the rest.
  - Round to nearest, ties to even. A mantissa carry-out gives e += 1.
  - e ≥ 255 → signed inf, overflow = 1, inexact = 1.
  - e ≤ 0 → signed zero (flush to zero), underflow = 1, inexact = 1.
  - Otherwise pack the result; inexact = guard | sticky.
- **DONE.** out_valid = 1. out and out_flags are held stable until out_valid && out_ready, then go to IDLE.
- No overlap: in_ready = 0 in every state except IDLE.

## Timing
- Reset values, applied immediately and asynchronously: state IDLE, out_valid 0, out 0x00000000, out_flags 0, accumulator and counter 0. in_ready reads 1 during and after reset.
- Let accept edge = edge 0.
  - Normal operands: out_valid rises after edge N+2, which is edge 26 for BITS_PER_CYCLE = 1.
  - Special operands: out_valid rises after edge 1.
- Result handshake:
  - The output transfer completes on the edge where out_valid && out_ready.
  - The next input can be accepted no earlier than the edge after that transfer.
  - Minimum initiation interval is N+4 cycles.
- out_ready held high while entering DONE: result held for exactly one cycle.
- in_valid asserted outside IDLE: ignored. Operands are not sampled.
- Reset mid-MUL or in DONE: the operation is discarded. No out_valid pulse after release.
- out, out_flags: change only on the edge that enters DONE.

## Structure
- Package `fp_pkg` holds:
  - `fp32_t`, a packed struct {sign, exp[7:0], frac[22:0]}.
  - `fp_flags_t`.
  - Constants `FP_BIAS` = 127, `FP_QNAN` = 0x7FC00000, `FP_PINF`, `FP_NINF`.
  - The FSM state enum.
- Sub-module `fp_round_pack` is combinational: 48-bit product + exponent + sign in, packed result + flags out. The divider reuses it.

## Test plan
- 0x3FC00000 × 0x40000000 → 0x40400000 (3.0), flags 0000, out_valid exactly 26 edges after accept.
- 0x7F800000 × 0x00000000 → 0x7FC00000, flags 1000, out_valid 1 edge after accept.
- 0x7F7FFFFF × 0x40000000 → 0x7F800000, flags 0101. Also 0x00800000 × 0x3F000000 → 0x00000000, flags 0011.
- 0x3F800001 × 0x3F800001 → 0x3F800002, flags 0001 (round to nearest, ties to even). 0xC0000000 × 0x3F800000 → 0xC0000000, flags 0000.
- Backpressure: out_ready low 5 cycles in DONE.
  - out and out_flags stay stable, in_ready stays 0.
  - A concurrent in_valid with new operands is not accepted.
  - Raise out_ready: transfer, IDLE on the next edge, then the new operands are accepted.
- rst_n pulsed low at edge 10 of MUL:
  - out_valid and out go to 0 immediately and no stale result appears.
  - A following 0x40400000 × 0x40400000 → 0x41100000.
  - Repeat all of the above with BITS_PER_CYCLE = 4: latency 8 edges.
